// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// S_HALT exists only when IF_MISALIGN_CHECK_EN is defined.
package if_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
`ifdef IF_MISALIGN_CHECK_EN
    , S_HALT
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;
  localparam logic [31:0] PC_STEP_C  = 32'd4;
  localparam logic [31:0] RESET_PC_C = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Next-state and next-PC selection for the fetch FSM (redirect > consume-advance > hold).
// Misaligned-redirect trap present only when IF_MISALIGN_CHECK_EN is defined.
module if_next_pc
  import if_pkg::*;
(
  input  fetch_state_e state,
  input  logic [31:0]  pc_r,
  input  logic         redirect,
  input  logic [31:0]  redirect_tgt,
  input  logic         rvalid,
  input  logic         consume,
`ifdef IF_MISALIGN_CHECK_EN
  input  logic         misalign,
  input  logic         halt_pend,
  output logic         inflight,
`endif
  output fetch_state_e state_next,
  output logic [31:0]  pc_next
);

  logic outstanding;

  // A request is still owed a response after this cycle only if none arrives now.
  always_comb begin
    outstanding = ((state == S_WAIT) || (state == S_DROP)) && !rvalid;
`ifdef IF_MISALIGN_CHECK_EN
    if ((state == S_HALT) && halt_pend && !rvalid) begin
      outstanding = 1'b1;
    end
`endif
  end

`ifdef IF_MISALIGN_CHECK_EN
  assign inflight = outstanding;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc_r;
    if (redirect) begin
      pc_next    = redirect_tgt;
      state_next = outstanding ? S_DROP : S_REQ;
`ifdef IF_MISALIGN_CHECK_EN
      if (misalign) begin
        state_next = S_HALT;
      end
`endif
    end else if (consume) begin
      pc_next    = pc_r + PC_STEP_C;
      state_next = (state == S_HOLD) ? S_REQ : S_WAIT;
    end else begin
      case (state)
        S_IDLE:  state_next = S_REQ;
        S_REQ:   state_next = S_WAIT;
        S_WAIT:  if (rvalid) state_next = S_HOLD;
        S_DROP:  if (rvalid) state_next = S_REQ;
        default: state_next = state;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, single outstanding imem request, one-entry hold buffer.
// Define IF_MISALIGN_CHECK_EN to trap misaligned redirects (adds fetch_misalign_o and S_HALT).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_C,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_r, pc_next, hold_inst, redirect_tgt;
  logic         consume, hold_load;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign, halt_pend, inflight;
  assign misalign         = |redirect_pc[1:0];
  assign redirect_tgt     = redirect_pc;
  assign fetch_misalign_o = (state == S_HALT);
`else
  assign redirect_tgt = redirect_pc & ~32'h3;
`endif

  assign consume   = (((state == S_WAIT) && imem_rvalid) || (state == S_HOLD)) && !stall && !redirect;
  assign hold_load = (state == S_WAIT) && imem_rvalid && !consume && !redirect;
  assign pc_o      = pc_r;

  if_next_pc u_next_pc (
    .state        (state),
    .pc_r         (pc_r),
    .redirect     (redirect),
    .redirect_tgt (redirect_tgt),
    .rvalid       (imem_rvalid),
    .consume      (consume),
`ifdef IF_MISALIGN_CHECK_EN
    .misalign     (misalign),
    .halt_pend    (halt_pend),
    .inflight     (inflight),
`endif
    .state_next   (state_next),
    .pc_next      (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc_r      <= RESET_PC;
      hold_inst <= NOP_INST;
    end else begin
      state <= state_next;
      pc_r  <= pc_next;
      if (redirect) begin
        hold_inst <= NOP_INST;
      end else if (hold_load) begin
        hold_inst <= imem_rdata;
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  // Remember a killed request still in flight so it is dropped after leaving S_HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_pend <= 1'b0;
    end else begin
      halt_pend <= (state_next == S_HALT) && inflight;
    end
  end
`endif

  // WAIT bypasses the response straight through and issues the next fetch in the same cycle.
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = pc_r;
    inst_valid_o = 1'b0;
    inst_o       = NOP_INST;
    case (state)
      S_REQ: imem_req = !redirect;
      S_WAIT: begin
        inst_valid_o = imem_rvalid;
        if (imem_rvalid) begin
          inst_o = imem_rdata;
        end
        if (consume) begin
          imem_req  = 1'b1;
          imem_addr = pc_r + PC_STEP_C;
        end
      end
      S_HOLD: begin
        inst_valid_o = 1'b1;
        inst_o       = hold_inst;
      end
      default: ;
    endcase
  end

endmodule
